// File: rtl/ysyx_22050019_icache.sv
// Direct-mapped read-only instruction cache: 128-bit lines, two-beat 64-bit refill, fence.i flush.
// Optional hit/miss counters are built when ICACHE_PERF_EN is defined.
module ysyx_22050019_icache #(
  parameter int SETS  = 16,
  parameter int IDX_W = $clog2(SETS),
  parameter int TAG_W = 28 - IDX_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         ar_valid_i,
  output logic         ar_ready_o,
  input  logic [31:0]  ar_addr_i,
  output logic         r_valid_o,
  input  logic         r_ready_i,
  output logic [127:0] r_data_o,
  output logic [1:0]   r_resp_o,
  input  logic         fence_i_i,
  output logic         mem_ar_valid_o,
  input  logic         mem_ar_ready_i,
  output logic [31:0]  mem_ar_addr_o,
  output logic [7:0]   mem_ar_len_o,
  output logic [2:0]   mem_ar_size_o,
  input  logic         mem_r_valid_i,
  output logic         mem_r_ready_o,
  input  logic [63:0]  mem_r_data_i,
  input  logic [1:0]   mem_r_resp_i,
  input  logic         mem_r_last_i,
  output logic [31:0]  perf_hit_o,
  output logic [31:0]  perf_miss_o
);

  // Handshakes: a transfer happens on a clk edge where valid and ready are both high;
  // a valid source holds its payload stable until that edge.
  typedef enum logic [2:0] {S_IDLE, S_LOOKUP, S_MISS_AR, S_MISS_R, S_RESP} state_t;

  state_t            r_state;
  logic [31:4]       r_addr;
  logic [SETS-1:0]   r_valid;
  logic [TAG_W-1:0]  r_tag  [SETS];
  logic [127:0]      r_line [SETS];
  logic [63:0]       r_beat0;
  logic              r_beat;
  logic              r_err;
  logic              r_fence_pend;

  logic [IDX_W-1:0]  w_idx;
  logic [TAG_W-1:0]  w_tag;
  logic              w_hit;
  logic              w_beat_done;
  logic              w_err;
  logic              w_fill_ok;
  logic [127:0]      w_line;
  logic              w_unused;

  assign w_idx       = r_addr[4+IDX_W-1:4];
  assign w_tag       = r_addr[31:4+IDX_W];
  assign w_hit       = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
  // A last flag on beat 0 is a short burst: finish the refill, but as an error.
  assign w_beat_done = mem_r_last_i || r_beat;
  assign w_err       = r_err || (mem_r_resp_i != 2'd0) || (mem_r_last_i && !r_beat);
  assign w_line      = r_beat ? {mem_r_data_i, r_beat0} : {64'd0, mem_r_data_i};
  assign w_fill_ok   = (r_state == S_MISS_R) && mem_r_valid_i && w_beat_done && !w_err;
  assign w_unused    = ^ar_addr_i[3:0];

  assign ar_ready_o    = (r_state == S_IDLE) && !fence_i_i && !r_fence_pend;
  assign mem_ar_addr_o = {r_addr, 4'b0000};
  assign mem_ar_len_o  = 8'd1;
  assign mem_ar_size_o = 3'b011;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state        <= S_IDLE;
      r_addr         <= '0;
      r_valid        <= '0;
      r_beat0        <= '0;
      r_beat         <= 1'b0;
      r_err          <= 1'b0;
      r_fence_pend   <= 1'b0;
      r_valid_o      <= 1'b0;
      r_data_o       <= '0;
      r_resp_o       <= 2'd0;
      mem_ar_valid_o <= 1'b0;
      mem_r_ready_o  <= 1'b0;
    end else begin
      if (fence_i_i && (r_state != S_IDLE)) r_fence_pend <= 1'b1;
      case (r_state)
        S_IDLE: begin
          if (fence_i_i || r_fence_pend) begin
            r_valid      <= '0;
            r_fence_pend <= 1'b0;
          end else if (ar_valid_i) begin
            r_addr  <= ar_addr_i[31:4];
            r_state <= S_LOOKUP;
          end
        end
        S_LOOKUP: begin
          if (w_hit) begin
            r_data_o  <= r_line[w_idx];
            r_resp_o  <= 2'd0;
            r_valid_o <= 1'b1;
            r_state   <= S_RESP;
          end else begin
            mem_ar_valid_o <= 1'b1;
            r_state        <= S_MISS_AR;
          end
        end
        S_MISS_AR: begin
          if (mem_ar_ready_i) begin
            mem_ar_valid_o <= 1'b0;
            mem_r_ready_o  <= 1'b1;
            r_beat         <= 1'b0;
            r_state        <= S_MISS_R;
          end
        end
        S_MISS_R: begin
          if (mem_r_valid_i) begin
            r_err <= w_err;
            if (w_beat_done) begin
              mem_r_ready_o <= 1'b0;
              r_beat        <= 1'b0;
              if (w_err) r_valid[w_idx] <= 1'b0;
              else       r_valid[w_idx] <= 1'b1;
              r_data_o  <= w_line;
              r_resp_o  <= w_err ? 2'd2 : 2'd0;
              r_valid_o <= 1'b1;
              r_state   <= S_RESP;
            end else begin
              r_beat0 <= mem_r_data_i;
              r_beat  <= 1'b1;
            end
          end
        end
        S_RESP: begin
          if (r_ready_i) begin
            r_valid_o <= 1'b0;
            r_err     <= 1'b0;
            r_state   <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Line payload and tags need no reset: the valid bits gate every use.
  always_ff @(posedge clk) begin
    if (w_fill_ok) begin
      r_line[w_idx] <= w_line;
      r_tag[w_idx]  <= w_tag;
    end
  end

`ifdef ICACHE_PERF_EN
  logic [31:0] r_perf_hit;
  logic [31:0] r_perf_miss;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_perf_hit  <= '0;
      r_perf_miss <= '0;
    end else if (r_state == S_LOOKUP) begin
      if (w_hit && (r_perf_hit != 32'hFFFF_FFFF))    r_perf_hit  <= r_perf_hit + 32'd1;
      if (!w_hit && (r_perf_miss != 32'hFFFF_FFFF))  r_perf_miss <= r_perf_miss + 32'd1;
    end
  end

  assign perf_hit_o  = r_perf_hit;
  assign perf_miss_o = r_perf_miss;
`else
  assign perf_hit_o  = 32'd0;
  assign perf_miss_o = 32'd0;
`endif

endmodule

// File: doc/ysyx_22050019_icache.md
Name: ysyx_22050019_icache

Overview:
Direct-mapped, read-only instruction cache that sits directly downstream of the fetch buffer. It serves 128-bit cache lines on a simplified AXI read channel (ar/r, single beat per request) and refills misses from memory over an AXI read channel with 64-bit beats, two beats per burst. Line storage is register-based. A fence.i pulse invalidates the whole cache.

Parameters:
SETS, 16, number of lines; power of two, index width IDX_W = log2(SETS)
TAG_W, 28-IDX_W, tag width; address bits [31:4+IDX_W]

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
ar_valid_i  in  1  line request valid (from fetch buffer)
ar_ready_o  out  1  request accepted
ar_addr_i  in  32  request address; bits [3:0] ignored
r_valid_o  out  1  line data valid
r_ready_i  in  1  fetch buffer accepts line
r_data_o  out  128  cache line
r_resp_o  out  2  0 = OKAY, 2 = SLVERR
fence_i_i  in  1  invalidate-all pulse
mem_ar_valid_o  out  1  memory read request valid
mem_ar_ready_i  in  1  memory accepts request
mem_ar_addr_o  out  32  line-aligned address
mem_ar_len_o  out  8  burst length, constant 8'd1 (two beats)
mem_ar_size_o  out  3  constant 3'b011 (8 bytes)
mem_r_valid_i  in  1  memory beat valid
mem_r_ready_o  out  1  cache accepts beat
mem_r_data_i  in  64  beat data
mem_r_resp_i  in  2  beat response
mem_r_last_i  in  1  last beat of burst
perf_hit_o  out  32  hit counter (optional feature)
perf_miss_o  out  32  miss counter (optional feature)

Behaviour:
- Reset, rst_n=0 at a clk edge: state=IDLE, all valid bits=0, fence_pend=0, err=0, beat counter=0. Outputs: ar_ready_o=1, r_valid_o=0, r_resp_o=0, r_data_o=0, mem_ar_valid_o=0, mem_r_ready_o=0.
- Reset mid-transaction abandons any outstanding memory burst. The memory side shares rst_n.
- Address split: offset=[3:0], index=[4+IDX_W-1:4], tag=[31:4+IDX_W].
- FSM states: IDLE, LOOKUP, MISS_AR, MISS_R, RESP.
- IDLE:
  - ar_ready_o=1 unless fence_i_i or fence_pend is set.
  - A fence clears all valid bits in this cycle and clears fence_pend. No request is accepted in that cycle.
  - On ar_valid_i & ar_ready_o: latch the address, go to LOOKUP.
- LOOKUP:
  - Hit (valid[idx] & tag match): load r_data_o from the line, r_resp_o=0, go to RESP.
  - Miss: go to MISS_AR.
  - Hit latency: accept edge, then r_valid_o high 2 cycles later.
- MISS_AR:
  - mem_ar_valid_o=1, mem_ar_addr_o={addr[31:4],4'b0}.
  - mem_ar_valid_o and the address are held stable until mem_ar_ready_i. On handshake go to MISS_R.
- MISS_R:
  - mem_r_ready_o=1.
  - Beat 0 is written to line bits [63:0]; beat 1 to bits [127:64].
  - Any beat with resp!=0 sets err.
  - mem_r_last_i on beat 0 sets err (short burst).
  - On the last beat: if err=0, write data and tag and set valid. If err=1, leave valid[idx] unchanged-cleared, i.e. force it to 0. Load r_data_o with the assembled line, set r_resp_o = err ? 2 : 0, go to RESP.
- RESP:
  - r_valid_o=1; r_data_o and r_resp_o are held stable until r_ready_i.
  - On handshake: r_valid_o=0, err=0, go to IDLE.
- fence_i_i outside IDLE sets fence_pend. It takes effect on the first IDLE cycle, so a line filled during the fence is invalidated.
- ar_valid_i outside IDLE is ignored (ar_ready_o=0).

Optional Feature:
Macro ICACHE_PERF_EN.
- Defined: perf_hit_o increments on each LOOKUP hit; perf_miss_o increments on each LOOKUP miss. Both are 32-bit, saturate at 32'hFFFFFFFF, and reset to 0. Fence does not clear them.
- Undefined: both ports are tied to 0 and no counter logic is synthesised.

Test Plan:
1. Cold miss: after reset, ar 0x80000000; memory returns beat0 64'h1111_1111_2222_2222, beat1 64'h3333_3333_4444_4444.
   -> mem_ar_addr_o=0x80000000, mem_ar_len_o=1.
   -> r_data_o=128'h3333_3333_4444_4444_1111_1111_2222_2222, r_resp_o=0.
2. Hit: repeat ar 0x8000000C.
   -> no mem_ar_valid_o; r_valid_o high 2 cycles after accept with the same line.
   -> PERF_EN: perf_hit_o=1, perf_miss_o=1.
3. Conflict: ar 0x80000100 (same index 0), fill with beats A/B, then ar 0x80000000.
   -> both requests miss; second returns a fresh memory line.
4. Error: miss with mem_r_resp_i=2 on beat 1.
   -> r_resp_o=2.
   -> next ar to the same address misses again.
5. Backpressure: hold r_ready_i=0 for 3 cycles in RESP.
   -> r_valid_o, r_data_o and r_resp_o stable; returns to IDLE on the cycle after r_ready_i=1.
6. Fence:
   -> pulse in IDLE: ar_ready_o=0 that cycle; next access to 0x80000000 misses.
   -> pulse during MISS_R: line still returned with resp 0; next access to the same line misses.
